// File: rtl/video_timing_pkg.sv
// Shared constants and types for the 720p raster timing driver.
package video_timing_pkg;

  localparam int unsigned CNT_W = 11;
  localparam int unsigned RGB_W = 24;

  localparam int unsigned DEF_H_SYNC  = 40;
  localparam int unsigned DEF_H_BACK  = 220;
  localparam int unsigned DEF_H_DISP  = 1280;
  localparam int unsigned DEF_H_FRONT = 110;
  localparam int unsigned DEF_V_SYNC  = 5;
  localparam int unsigned DEF_V_BACK  = 20;
  localparam int unsigned DEF_V_DISP  = 720;
  localparam int unsigned DEF_V_FRONT = 5;

  localparam int unsigned DEF_H_TOTAL = DEF_H_SYNC + DEF_H_BACK + DEF_H_DISP + DEF_H_FRONT;
  localparam int unsigned DEF_V_TOTAL = DEF_V_SYNC + DEF_V_BACK + DEF_V_DISP + DEF_V_FRONT;

  // Raw (polarity-free) timing flags carried through the latency-matching delay line.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic fs;
  } timing_t;

  function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                     input int unsigned lo,
                                     input int unsigned len);
    return (cnt >= CNT_W'(lo)) && (cnt < CNT_W'(lo + len));
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Horizontal/vertical raster counters and region decode (sync, active, frame start, coordinates).
module video_timing_counter
  import video_timing_pkg::*;
#(
  parameter int unsigned H_SYNC  = DEF_H_SYNC,
  parameter int unsigned H_BACK  = DEF_H_BACK,
  parameter int unsigned H_DISP  = DEF_H_DISP,
  parameter int unsigned H_FRONT = DEF_H_FRONT,
  parameter int unsigned V_SYNC  = DEF_V_SYNC,
  parameter int unsigned V_BACK  = DEF_V_BACK,
  parameter int unsigned V_DISP  = DEF_V_DISP,
  parameter int unsigned V_FRONT = DEF_V_FRONT
) (
  input  logic              pixel_clk,
  input  logic              rst_n,
  output logic              raw_hs,
  output logic              raw_vs,
  output logic              raw_de,
  output logic              raw_fs,
  output logic [CNT_W-1:0]  xpos,
  output logic [CNT_W-1:0]  ypos
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
  localparam logic [CNT_W-1:0] H_ACT_LO = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] V_ACT_LO = CNT_W'(V_SYNC + V_BACK);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             h_wrap;
  logic             req_active;

  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    raw_hs     = (h_cnt_q < CNT_W'(H_SYNC));
    raw_vs     = (v_cnt_q < CNT_W'(V_SYNC));
    req_active = in_window(h_cnt_q, H_SYNC + H_BACK, H_DISP) &&
                 in_window(v_cnt_q, V_SYNC + V_BACK, V_DISP);
    raw_de     = req_active;
    raw_fs     = (h_cnt_q == '0) && (v_cnt_q == '0);
    xpos       = req_active ? h_cnt_q - H_ACT_LO : '0;
    ypos       = req_active ? v_cnt_q - V_ACT_LO : '0;
  end

endmodule

// File: rtl/video_timing_driver.sv
// 720p60 raster timing with a DATA_LAT-stage delay line so hs/vs/de line up with returned pixel data.
module video_timing_driver
  import video_timing_pkg::*;
#(
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned H_DISP   = DEF_H_DISP,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter int unsigned V_DISP   = DEF_V_DISP,
  parameter int unsigned V_FRONT  = DEF_V_FRONT,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1,
  parameter int unsigned DATA_LAT = 1
) (
  input  logic              pixel_clk,
  input  logic              rst_n,
  input  logic [RGB_W-1:0]  pixel_data,
  output logic [CNT_W-1:0]  pixel_xpos,
  output logic [CNT_W-1:0]  pixel_ypos,
  output logic              video_hs,
  output logic              video_vs,
  output logic              video_de,
  output logic [RGB_W-1:0]  video_rgb,
  output logic              frame_start
);

  logic    raw_hs, raw_vs, raw_de, raw_fs;
  timing_t raw;
  timing_t dly_q [DATA_LAT];
  timing_t dly_d [DATA_LAT];
  timing_t tap;

  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             de_q, de_d;
  logic             fs_q, fs_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;

  video_timing_counter #(
    .H_SYNC  (H_SYNC),
    .H_BACK  (H_BACK),
    .H_DISP  (H_DISP),
    .H_FRONT (H_FRONT),
    .V_SYNC  (V_SYNC),
    .V_BACK  (V_BACK),
    .V_DISP  (V_DISP),
    .V_FRONT (V_FRONT)
  ) u_counter (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .raw_hs    (raw_hs),
    .raw_vs    (raw_vs),
    .raw_de    (raw_de),
    .raw_fs    (raw_fs),
    .xpos      (pixel_xpos),
    .ypos      (pixel_ypos)
  );

  always_comb begin
    raw.hs = raw_hs;
    raw.vs = raw_vs;
    raw.de = raw_de;
    raw.fs = raw_fs;
    dly_d[0] = raw;
    for (int unsigned i = 1; i < DATA_LAT; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DATA_LAT; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      dly_q <= dly_d;
    end
  end

  // Last delay stage matches the generator latency; pixel_data is only sampled under its de.
  always_comb begin
    tap   = dly_q[DATA_LAT-1];
    hs_d  = tap.hs ? HS_POL : ~HS_POL;
    vs_d  = tap.vs ? VS_POL : ~VS_POL;
    de_d  = tap.de;
    fs_d  = tap.fs;
    rgb_d = tap.de ? pixel_data : '0;
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      de_q  <= 1'b0;
      fs_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= de_d;
      fs_q  <= fs_d;
      rgb_q <= rgb_d;
    end
  end

  assign video_hs    = hs_q;
  assign video_vs    = vs_q;
  assign video_de    = de_q;
  assign video_rgb   = rgb_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_driver.sv
// Directed bench: full 720p instance (DATA_LAT=1) plus a tiny-raster instance (DATA_LAT=3, hs active-low).
module tb_video_timing_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  // Full 720p instance with a 1-cycle generator.
  logic        rst1_n;
  logic [23:0] pd1, gen1;
  logic [10:0] xpos1, ypos1;
  logic        hs1, vs1, de1, fs1;
  logic [23:0] rgb1;

  video_timing_driver u_dut_720p (
    .pixel_clk   (clk),
    .rst_n       (rst1_n),
    .pixel_data  (pd1),
    .pixel_xpos  (xpos1),
    .pixel_ypos  (ypos1),
    .video_hs    (hs1),
    .video_vs    (vs1),
    .video_de    (de1),
    .video_rgb   (rgb1),
    .frame_start (fs1)
  );

  always @(posedge clk) gen1 <= {2'b00, xpos1, ypos1};
  assign pd1 = gen1;

  // Tiny raster: H 3/2/6/2 (13), V 2/1/3/1 (7), 91-cycle frame, latency 3+1.
  logic        rst3_n;
  logic        mask3;
  logic [23:0] pd3, g3a, g3b, g3c;
  logic [10:0] xpos3, ypos3;
  logic        hs3, vs3, de3, fs3;
  logic [23:0] rgb3;

  video_timing_driver #(
    .H_SYNC   (3),
    .H_BACK   (2),
    .H_DISP   (6),
    .H_FRONT  (2),
    .V_SYNC   (2),
    .V_BACK   (1),
    .V_DISP   (3),
    .V_FRONT  (1),
    .HS_POL   (1'b0),
    .VS_POL   (1'b1),
    .DATA_LAT (3)
  ) u_dut_small (
    .pixel_clk   (clk),
    .rst_n       (rst3_n),
    .pixel_data  (pd3),
    .pixel_xpos  (xpos3),
    .pixel_ypos  (ypos3),
    .video_hs    (hs3),
    .video_vs    (vs3),
    .video_de    (de3),
    .video_rgb   (rgb3),
    .frame_start (fs3)
  );

  always @(posedge clk) begin
    g3a <= {2'b00, xpos3, ypos3};
    g3b <= g3a;
    g3c <= g3b;
  end
  assign pd3 = mask3 ? 24'hFFFFFF : g3c;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp_v);
    end
  endtask

  // Event tracker shared by both phases (one DUT observed at a time).
  int hs_rise1, hs_fall1, hs_rise2, vs_fall, fs_cnt, fs_last;
  int de_first, de_lines, run_err, rgb_err, blank_err, col, row;
  logic hs_p, vs_p, de_p;
  logic [23:0] first_rgb;

  task automatic scan_reset();
    hs_rise1 = -1; hs_fall1 = -1; hs_rise2 = -1; vs_fall = -1;
    fs_cnt = 0; fs_last = -1; de_first = -1; de_lines = 0;
    run_err = 0; rgb_err = 0; blank_err = 0; col = 0; row = 0;
    hs_p = 1'b0; vs_p = 1'b0; de_p = 1'b0; first_rgb = '0;
  endtask

  task automatic scan_cycle(input int c, input logic hs, input logic vs, input logic de,
                            input logic fs, input logic [23:0] rgb, input int h_disp);
    logic [23:0] exp_rgb;
    if (hs && !hs_p) begin
      if (hs_rise1 < 0) hs_rise1 = c;
      else if (hs_rise2 < 0) hs_rise2 = c;
    end
    if (!hs && hs_p && hs_fall1 < 0) hs_fall1 = c;
    if (!vs && vs_p && vs_fall < 0) vs_fall = c;
    if (fs) begin
      fs_cnt++;
      fs_last = c;
      row = 0;
    end
    if (de) begin
      if (de_first < 0) begin
        de_first  = c;
        first_rgb = rgb;
      end
      exp_rgb = {2'b00, 11'(col), 11'(row)};
      if (rgb !== exp_rgb) rgb_err++;
      col++;
    end else begin
      if (de_p) begin
        if (col != h_disp) run_err++;
        de_lines++;
        row++;
        col = 0;
      end
      if (rgb !== 24'h0) blank_err++;
    end
    hs_p = hs; vs_p = vs; de_p = de;
  endtask

  task automatic small_run(input string pfx);
    @(negedge clk);
    rst3_n = 1'b1;
    cyc = 0;
    check_eq({pfx, "rst_hs"}, 32'(hs3), 32'd1);
    check_eq({pfx, "rst_de_rgb"}, {7'd0, de3, rgb3}, 32'd0);
    scan_reset();
    for (int i = 1; i <= 190; i++) begin
      @(negedge clk);
      cyc = i;
      scan_cycle(cyc, ~hs3, vs3, de3, fs3, rgb3, 6);
      if (cyc == 46) check_eq({pfx, "xy_46"}, {10'd0, xpos3, ypos3}, {10'd0, 11'd2, 11'd0});
      if (cyc == 74) check_eq({pfx, "xy_74"}, {10'd0, xpos3, ypos3}, {10'd0, 11'd4, 11'd2});
      if (cyc == 76) check_eq({pfx, "xy_76"}, {10'd0, xpos3, ypos3}, 32'd0);
    end
    check_eq({pfx, "hs_rise1"}, 32'(hs_rise1), 32'd4);
    check_eq({pfx, "hs_fall1"}, 32'(hs_fall1), 32'd7);
    check_eq({pfx, "hs_rise2"}, 32'(hs_rise2), 32'd17);
    check_eq({pfx, "vs_fall"},  32'(vs_fall),  32'd30);
    check_eq({pfx, "de_first"}, 32'(de_first), 32'd48);
    check_eq({pfx, "first_rgb"}, {8'd0, first_rgb}, 32'd0);
    check_eq({pfx, "fs_cnt"},   32'(fs_cnt),   32'd3);
    check_eq({pfx, "fs_last"},  32'(fs_last),  32'd186);
    check_eq({pfx, "de_lines"}, 32'(de_lines), 32'd6);
    check_eq({pfx, "run_len"},  32'(run_err),  32'd0);
    check_eq({pfx, "rgb_pat"},  32'(rgb_err),  32'd0);
    check_eq({pfx, "blank"},    32'(blank_err), 32'd0);
  endtask

  initial begin
    int mask_err, de_cnt;
    rst1_n = 1'b0;
    rst3_n = 1'b0;
    mask3  = 1'b0;
    repeat (3) @(negedge clk);

    // 720p, DATA_LAT=1: release and follow through the first three active lines.
    rst1_n = 1'b1;
    cyc = 0;
    check_eq("p_rst_sync", {30'd0, hs1, vs1}, 32'd0);
    check_eq("p_rst_de_rgb_fs", {6'd0, de1, fs1, rgb1}, 32'd0);
    check_eq("p_rst_xy", {10'd0, xpos1, ypos1}, 32'd0);
    scan_reset();
    for (int i = 1; i <= 41512 + 3 * 1650; i++) begin
      @(negedge clk);
      cyc = i;
      scan_cycle(cyc, hs1, vs1, de1, fs1, rgb1, 1280);
    end
    check_eq("p_hs_rise1", 32'(hs_rise1), 32'd2);
    check_eq("p_hs_fall1", 32'(hs_fall1), 32'd42);
    check_eq("p_hs_rise2", 32'(hs_rise2), 32'd1652);
    check_eq("p_vs_fall",  32'(vs_fall),  32'd8252);
    check_eq("p_fs_cnt",   32'(fs_cnt),   32'd1);
    check_eq("p_fs_cyc",   32'(fs_last),  32'd2);
    check_eq("p_de_first", 32'(de_first), 32'd41512);
    check_eq("p_first_rgb", {8'd0, first_rgb}, 32'd0);
    check_eq("p_de_lines", 32'(de_lines), 32'd3);
    check_eq("p_run_len",  32'(run_err),  32'd0);
    check_eq("p_rgb_pat",  32'(rgb_err),  32'd0);
    check_eq("p_blank",    32'(blank_err), 32'd0);

    // Tiny raster, DATA_LAT=3.
    small_run("s_");

    // Constant all-ones pixel data must only appear under de.
    mask3 = 1'b1;
    mask_err = 0;
    de_cnt = 0;
    for (int i = 0; i < 91; i++) begin
      @(negedge clk);
      cyc++;
      if (de3) begin
        de_cnt++;
        if (rgb3 !== 24'hFFFFFF) mask_err++;
      end else if (rgb3 !== 24'h0) begin
        mask_err++;
      end
    end
    mask3 = 1'b0;
    check_eq("m_mask", 32'(mask_err), 32'd0);
    check_eq("m_de_cnt", 32'(de_cnt), 32'd18);

    // Mid-frame reset inside the active window, held for three edges.
    for (int i = 0; i < 91 && (cyc % 91) != 74; i++) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("r_pre_xpos", 32'(xpos3), 32'd4);
    rst3_n = 1'b0;
    @(negedge clk);
    check_eq("r_sync", {30'd0, hs3, vs3}, 32'd2);
    check_eq("r_de_rgb_fs", {6'd0, de3, fs3, rgb3}, 32'd0);
    check_eq("r_xy", {10'd0, xpos3, ypos3}, 32'd0);
    @(negedge clk);
    small_run("r_");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/video_timing_driver.md
Name: video_timing_driver

Overview:
- Consumer end of the pixel-coordinate/pixel-data interface. The block drives pixel_xpos/pixel_ypos to the pattern or display generator and accepts pixel_data back a fixed DATA_LAT cycles later.
- Generates 720p60 raster timing (hs, vs, de) and aligns the returned pixel_data with it.
- Outputs feed the HDMI/TMDS encoder stage.

Parameters:
- H_SYNC, 40, hsync width in pixel clocks
- H_BACK, 220, horizontal back porch
- H_DISP, 1280, active pixels per line
- H_FRONT, 110, horizontal front porch
- V_SYNC, 5, vsync width in lines
- V_BACK, 20, vertical back porch
- V_DISP, 720, active lines
- V_FRONT, 5, vertical front porch
- HS_POL, 1'b1, active level of video_hs
- VS_POL, 1'b1, active level of video_vs
- DATA_LAT, 1, generator latency in cycles from xpos/ypos to pixel_data (range 1..4)

Ports:
- pixel_clk  in  1  pixel clock (74.25 MHz for 720p)
- rst_n  in  1  reset
- pixel_data  in  24  RGB888 from generator, valid DATA_LAT cycles after the coordinates
- pixel_xpos  out  11  requested column, 0..H_DISP-1
- pixel_ypos  out  11  requested row, 0..V_DISP-1
- video_hs  out  1  horizontal sync
- video_vs  out  1  vertical sync
- video_de  out  1  data enable
- video_rgb  out  24  pixel data, zero when video_de=0
- frame_start  out  1  one-cycle pulse at output position (h=0, v=0)

Interface: reset rst_n, synchronous, active-low; clock pixel_clk.

Behaviour:
- Totals: H_TOTAL = H_SYNC+H_BACK+H_DISP+H_FRONT (1650); V_TOTAL = V_SYNC+V_BACK+V_DISP+V_FRONT (750).
- h_cnt and v_cnt are 11-bit counters.
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments only on h_cnt wrap and wraps to 0 after V_TOTAL-1.
  - Both wrap in the same cycle at the end of a frame.
- Region order per axis: sync [0, SYNC), back porch, active [SYNC+BACK, SYNC+BACK+DISP), front porch.
- req_active = h_cnt in H active AND v_cnt in V active. It is combinational from the counter registers.
- Coordinates:
  - When req_active: pixel_xpos = h_cnt-(H_SYNC+H_BACK) and pixel_ypos = v_cnt-(V_SYNC+V_BACK).
  - Otherwise both are 0.
  - Both are driven combinationally from the counter registers and are never X.
- Timing pipeline: raw hs, vs, de and fs (h_cnt==0 AND v_cnt==0) are computed from the counters and then delayed DATA_LAT register stages, so they align with the returned pixel_data.
- Output register stage, applied to the delayed signals:
  - video_hs = hs ? HS_POL : ~HS_POL
  - video_vs likewise with VS_POL
  - video_de = de
  - video_rgb = de ? pixel_data : 0
  - frame_start = fs
- Latency: outputs at cycle k reflect counter state at cycle k-(DATA_LAT+1).
- vsync switches on the line boundary together with h_cnt = 0. There is no half-line offset (progressive only).
- Reset values, while rst_n=0 at an edge:
  - h_cnt=0, v_cnt=0, all delay stages cleared (de=0, hs/vs inactive, fs=0)
  - video_hs=~HS_POL, video_vs=~VS_POL, video_de=0, video_rgb=0, frame_start=0
  - pixel_xpos=0, pixel_ypos=0
- Reset mid-frame: on the next edge everything returns to the reset values above. The raster restarts at (0,0) once rst_n rises. No partial line is flushed.
- First cycle after release: the counters are at (0,0). The outputs keep their reset values for DATA_LAT+1 cycles, then hs/vs assert.
- pixel_data is ignored (masked) whenever delayed de=0. Its value outside the active window, including X, must not propagate.
- Widths: all subtraction is done in 11 bits. The parameters are guaranteed to give totals ≤ 2047.

Decomposition:
- Package video_timing_pkg holds:
  - 720p default constants (H_*/V_* values, H_TOTAL, V_TOTAL)
  - RGB888 width constant
  - a packed struct for {hs, vs, de, fs}, used by the delay line
- Sub-module video_timing_counter: h/v counters plus region decode (raw hs, vs, de, fs, req_active, xpos, ypos). The top level holds the DATA_LAT delay line and the output register.

Test Plan:
- Reset release, defaults, DATA_LAT=1 → video_hs active (1) on cycles 2..41 inclusive after release. Next hs rising edge at cycle 1652; line period 1650.
- Full frame with the generator modelled as a 1-cycle register of pixel_data = {2'b0, xpos[10:0], ypos[10:0]}:
  - first video_de=1 at cycle 41512
  - video_rgb there = {xpos=0, ypos=0}
  - de high for 1280 consecutive cycles per line, over 720 lines
  - video_rgb at each de cycle matches (col, row), with col running 0..1279
- Blanking masking: pixel_data forced to 24'hFFFFFF constantly → video_rgb=0 whenever video_de=0, and 24'hFFFFFF whenever video_de=1.
- Frame wrap: frame_start pulses exactly once per 1,237,500 cycles (1650×750), for one cycle. video_vs is active for 5×1650=8250 cycles starting at the same cycle as frame_start.
- Reset mid-frame: assert rst_n=0 at line 400, pixel 700 for 3 cycles → the next edge shows video_de=0, video_rgb=0, hs/vs inactive, xpos=ypos=0. After release the timing repeats scenario 1 exactly.
- DATA_LAT=3 with a 3-stage generator model → first video_de at cycle 41514, still carrying {0,0}. hs occupies cycles 4..43.
